fifo_ptr_ctrl: RTL
==================

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter OSTD_NUM, default 8: FIFO depth; power of two, >= 2.
REQ-002 SHALL have parameter PTR_SIZE, default $clog2(OSTD_NUM): pointer index width.
REQ-003 SHALL have parameter THRESHOLD, default OSTD_NUM-2: almost-full level, range 1..OSTD_NUM-1.
REQ-004 clk_in  input  1  clock; all state updates on rising edge.
REQ-005 sreset  input  1  reset; synchronous, active-high.
REQ-006 trans_write  input  1  transaction-side write request.
REQ-007 trans_read  input  1  transaction-side read request.
REQ-008 flush  input  1  synchronous FIFO clear request.
REQ-009 fifo_wenable  output  1  memory write strobe (accepted write).
REQ-010 fifo_renable  output  1  memory read strobe (accepted read).
REQ-011 write_ptr  output  PTR_SIZE  memory write address.
REQ-012 read_ptr  output  PTR_SIZE  memory read address.
REQ-013 fill_count  output  PTR_SIZE+1  current occupancy, 0..OSTD_NUM.
REQ-014 full  output  1  fill_count == OSTD_NUM.
REQ-015 empty  output  1  fill_count == 0.
REQ-016 almost_full  output  1  fill_count >= THRESHOLD.
REQ-017 rd_valid  output  1  memory read data valid, one cycle after fifo_renable.
REQ-018 wr_drop  output  1  one-cycle pulse: write request rejected.
REQ-019 rd_drop  output  1  one-cycle pulse: read request rejected.

Function
REQ-020 Internal pointers SHALL be PTR_SIZE+1 bits (extra wrap bit); write_ptr/read_ptr SHALL be the low PTR_SIZE bits.
REQ-021 fill_count SHALL equal wptr_ext - rptr_ext modulo 2^(PTR_SIZE+1), held in a register.
REQ-022 full, empty, almost_full SHALL be combinational decodes of registered fill_count only (no input-to-flag path).
REQ-023 Read accept: fifo_renable = trans_read && !empty && !flush; no write-to-read bypass when empty.
REQ-024 Write accept: fifo_wenable = trans_write && !flush && (!full || fifo_renable).
REQ-025 fifo_wenable/fifo_renable SHALL be combinational, same cycle as request; write_ptr/read_ptr shown that cycle are the addresses used.
REQ-026 On accepted write, write pointer SHALL increment by 1 next edge; from OSTD_NUM-1 index wraps to 0 and wrap bit toggles.
REQ-027 On accepted read, read pointer SHALL increment identically.
REQ-028 fill_count next = fill_count + wen - ren; simultaneous accepted read+write leaves it unchanged.
REQ-029 wr_drop SHALL be registered: asserted cycle after trans_write && !fifo_wenable && !flush.
REQ-030 rd_drop SHALL be registered: asserted cycle after trans_read && !fifo_renable && !flush.
REQ-031 rd_valid SHALL be registered copy of fifo_renable (1-cycle memory read latency).
REQ-032 flush=1 SHALL block both strobes that cycle and, next edge, zero both pointers, fill_count, rd_valid, wr_drop, rd_drop.
REQ-033 fill_count SHALL never exceed OSTD_NUM nor go below 0 under any input sequence.

Reset
REQ-034 sreset=1 at a rising edge SHALL zero both pointers (incl. wrap bits), fill_count, rd_valid, wr_drop, rd_drop; empty=1, full=0, almost_full=0 next cycle.
REQ-035 While sreset=1, fifo_wenable and fifo_renable SHALL be 0; sreset has priority over flush and requests.
REQ-036 Reset mid-operation SHALL discard all occupancy; no drop pulse generated by requests in reset cycle.

Verification (OSTD_NUM=8, THRESHOLD=6)
REQ-037 Reset, then 8 consecutive writes -> write_ptr 0..7 then 0, fill_count 8, full=1, almost_full from count 6, no wr_drop.
REQ-038 Full, trans_write alone -> fifo_wenable=0, wr_drop=1 next cycle, fill_count stays 8.
REQ-039 Full, trans_write+trans_read same cycle -> both strobes 1, fill_count stays 8, both pointers advance.
REQ-040 Empty, trans_read+trans_write -> fifo_renable=0, fifo_wenable=1, rd_drop=1 next cycle, fill_count 1.
REQ-041 Fill 5, read 3 (rd_valid each following cycle), then flush -> next cycle pointers 0, fill_count 0, empty=1.
REQ-042 Write 12 / read 12 interleaved across wrap -> pointers wrap at 8, fill_count consistent each cycle; sreset mid-stream -> all zero next cycle.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller: accepts read/write requests, drives memory
// strobes and addresses, and tracks fill level with wrap-bit pointers.
module fifo_ptr_ctrl #(
   parameter int OSTD_NUM  = 8,
   parameter int PTR_SIZE  = $clog2(OSTD_NUM),
   parameter int THRESHOLD = OSTD_NUM - 2
) (
   input  logic                clk_in,
   input  logic                sreset,
   input  logic                trans_write,
   input  logic                trans_read,
   input  logic                flush,
   output logic                fifo_wenable,
   output logic                fifo_renable,
   output logic [PTR_SIZE-1:0] write_ptr,
   output logic [PTR_SIZE-1:0] read_ptr,
   output logic [PTR_SIZE:0]   fill_count,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic                rd_valid,
   output logic                wr_drop,
   output logic                rd_drop
);

   localparam logic [PTR_SIZE:0] DEPTH_L = (PTR_SIZE+1)'(OSTD_NUM);
   localparam logic [PTR_SIZE:0] THR_L   = (PTR_SIZE+1)'(THRESHOLD);

   logic [PTR_SIZE:0] wptr_ext, rptr_ext;

   // Flags decode only the registered count, so no request reaches them combinationally.
   assign full        = (fill_count == DEPTH_L);
   assign empty       = (fill_count == '0);
   assign almost_full = (fill_count >= THR_L);

   assign write_ptr = wptr_ext[PTR_SIZE-1:0];
   assign read_ptr  = rptr_ext[PTR_SIZE-1:0];

   // A write into a full FIFO is allowed only when a read frees a slot the same cycle.
   assign fifo_renable = !sreset && !flush && trans_read && !empty;
   assign fifo_wenable = !sreset && !flush && trans_write && (!full || fifo_renable);

   always_ff @(posedge clk_in) begin
      if (sreset || flush) begin
         wptr_ext   <= '0;
         rptr_ext   <= '0;
         fill_count <= '0;
         rd_valid   <= 1'b0;
         wr_drop    <= 1'b0;
         rd_drop    <= 1'b0;
      end else begin
         if (fifo_wenable) wptr_ext <= wptr_ext + 1'b1;
         if (fifo_renable) rptr_ext <= rptr_ext + 1'b1;
         case ({fifo_wenable, fifo_renable})
            2'b10:   fill_count <= fill_count + 1'b1;
            2'b01:   fill_count <= fill_count - 1'b1;
            default: fill_count <= fill_count;
         endcase
         rd_valid <= fifo_renable;
         wr_drop  <= trans_write && !fifo_wenable;
         rd_drop  <= trans_read && !fifo_renable;
      end
   end

endmodule
